// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 widths, channel payload structs and write-arbiter state encoding.
// Imported by the write-path arbiter and its round-robin picker.
package axi4_globals_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int STRB_WIDTH    = DATA_WIDTH / 8;

    typedef struct packed {
        logic [3:0]               id;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } aw_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_arb_state_e;

endpackage

// File: rtl/axi4_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant in
// circular order, one-hot result plus a valid flag.
module axi4_rr_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] last_grant,
    output logic [NUM_MASTERS-1:0] next_grant,
    output logic                   valid
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    int            last_idx;
    logic [IW-1:0] idx;

    always_comb begin
        last_idx   = 0;
        idx        = '0;
        next_grant = '0;
        valid      = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (last_grant[i]) last_idx = i;
        end
        // Offset NUM_MASTERS wraps back to last_grant itself, so a lone
        // repeat requester is still served.
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            idx = IW'((last_idx + off) % NUM_MASTERS);
            if (!valid && req[idx]) begin
                next_grant[idx] = 1'b1;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// AXI4 write-path arbiter: one outstanding AW/W/B transaction at a time,
// round-robin between masters, W last regenerated from the captured length.
module axi4_wr_arbiter
    import axi4_globals_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [NUM_MASTERS-1:0] m_awvalid,
    output logic [NUM_MASTERS-1:0] m_awready,
    input  aw_t  [NUM_MASTERS-1:0] m_aw,
    input  logic [NUM_MASTERS-1:0] m_wvalid,
    output logic [NUM_MASTERS-1:0] m_wready,
    input  w_t   [NUM_MASTERS-1:0] m_w,
    output logic [NUM_MASTERS-1:0] m_bvalid,
    input  logic [NUM_MASTERS-1:0] m_bready,
    output b_t                     m_b,
    output logic                   s_awvalid,
    input  logic                   s_awready,
    output aw_t                    s_aw,
    output logic                   s_wvalid,
    input  logic                   s_wready,
    output w_t                     s_w,
    input  logic                   s_bvalid,
    output logic                   s_bready,
    input  b_t                     s_b,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   protocol_err
);

    wr_arb_state_e          state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] last_grant_q;
    logic [7:0]             len_q;
    logic [7:0]             beat_cnt_q;
    logic                   protocol_err_q;

    logic [NUM_MASTERS-1:0] arb_grant;
    logic                   arb_valid;

    aw_t  sel_aw;
    w_t   sel_w;
    logic sel_awvalid;
    logic sel_wvalid;
    logic sel_bready;
    logic regen_last;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    axi4_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .req        (m_awvalid),
        .last_grant (last_grant_q),
        .next_grant (arb_grant),
        .valid      (arb_valid)
    );

    // One-hot grant makes the owner's channels a plain select.
    always_comb begin
        sel_aw      = '0;
        sel_w       = '0;
        sel_awvalid = 1'b0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                sel_aw      = m_aw[i];
                sel_w       = m_w[i];
                sel_awvalid = m_awvalid[i];
                sel_wvalid  = m_wvalid[i];
                sel_bready  = m_bready[i];
            end
        end
    end

    assign regen_last = (beat_cnt_q == len_q);
    assign aw_hs      = (state_q == ADDR) && sel_awvalid && s_awready;
    assign w_hs       = (state_q == DATA) && sel_wvalid && s_wready;
    assign b_hs       = (state_q == RESP) && s_bvalid && sel_bready;

    always_comb begin
        state_d    = state_q;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m_awready  = '0;
        m_wready   = '0;
        m_bvalid   = '0;
        s_aw       = sel_aw;
        s_w.data   = sel_w.data;
        s_w.strb   = sel_w.strb;
        s_w.last   = regen_last;
        m_b        = s_b;
        case (state_q)
            IDLE: begin
                if (arb_valid) state_d = ADDR;
            end
            ADDR: begin
                s_awvalid = sel_awvalid;
                m_awready = grant_q & {NUM_MASTERS{s_awready}};
                if (aw_hs) state_d = DATA;
            end
            DATA: begin
                s_wvalid = sel_wvalid;
                m_wready = grant_q & {NUM_MASTERS{s_wready}};
                if (w_hs && regen_last) state_d = RESP;
            end
            RESP: begin
                s_bready = sel_bready;
                m_bvalid = grant_q & {NUM_MASTERS{s_bvalid}};
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves the highest master as last owner so master 0 wins first.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= {1'b1, {(NUM_MASTERS-1){1'b0}}};
            len_q          <= '0;
            beat_cnt_q     <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && arb_valid) begin
                grant_q <= arb_grant;
            end
            if (aw_hs) begin
                len_q      <= sel_aw.len;
                beat_cnt_q <= '0;
            end
            if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
                if (sel_w.last != regen_last) protocol_err_q <= 1'b1;
            end
            if (b_hs) begin
                last_grant_q <= grant_q;
                grant_q      <= '0;
            end
        end
    end

    assign grant        = grant_q;
    assign protocol_err = protocol_err_q;

endmodule
